// File: rtl/aurora_tx_framer_if.sv
// AXI-Stream link between the Aurora TX framer and the Aurora TX user interface.
// Two bytes per beat, with the first byte of each pair in tdata[15:8].
interface aurora_tx_framer_if;
  logic [15:0] tdata;
  logic [1:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/aurora_tx_framer.sv
// Captures one enable_in-delimited byte packet and sends it as a length header
// followed by the payload packed two bytes per word on an AXI-Stream master.
module aurora_tx_framer #(
  parameter int MAX_LEN = 1536,
  parameter int MIN_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_in,
  input  logic [7:0]           data_in,
  aurora_tx_framer_if.master   m,
  output logic                 busy,
  output logic [15:0]          pkt_cnt,
  output logic [15:0]          drop_cnt
);

  localparam int LW    = $clog2(MAX_LEN + 1);
  localparam int DEPTH = (MAX_LEN + 1) / 2;
  localparam int WAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WCW   = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);
  localparam logic [31:0]   MIN_L = 32'(MIN_LEN);

  typedef enum logic [2:0] {IDLE, RECV, CHECK, HDR, PAYLOAD, DROP} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [WCW-1:0]  wd_q, wd_d;
  logic            en_dly_q, en_dly_d;
  logic [15:0]     pkt_cnt_q, pkt_cnt_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;

  // Buffer is split into even/odd byte banks so a whole output word is one read.
  logic [7:0]      mem_even [DEPTH];
  logic [7:0]      mem_odd  [DEPTH];
  logic [7:0]      rd_even_q, rd_odd_q;
  logic            wr_en, wr_odd;
  logic [WAW-1:0]  wr_addr, rd_addr;

  logic            rise, hs, out_valid, last_word;
  logic [1:0]      drop_inc;
  logic            pkt_inc;
  logic [16:0]     drop_sum, pkt_sum;

  assign rise      = enable_in & ~en_dly_q;
  assign hs        = out_valid & m.tready;
  assign last_word = (LW'(wd_q) == ((len_q - LW'(1)) >> 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      wd_q       <= '0;
      en_dly_q   <= 1'b1;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wd_q       <= wd_d;
      en_dly_q   <= en_dly_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // The read address follows the next word index, so the RAM output always
  // holds the word currently presented, even across stalls.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_odd) mem_even[wr_addr] <= data_in;
    rd_even_q <= mem_even[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (wr_en && wr_odd) mem_odd[wr_addr] <= data_in;
    rd_odd_q <= mem_odd[rd_addr];
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wd_d     = wd_q;
    en_dly_d = enable_in;
    wr_en    = 1'b0;
    wr_odd   = 1'b0;
    wr_addr  = '0;
    drop_inc = 2'd0;
    pkt_inc  = 1'b0;

    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (rise) begin
          wr_en   = 1'b1;
          len_d   = LW'(1);
          state_d = RECV;
        end
      end
      RECV: begin
        if (!enable_in) begin
          state_d = CHECK;
        end else if (len_q == MAX_L) begin
          drop_inc = 2'd1;
          state_d  = DROP;
        end else begin
          wr_en   = 1'b1;
          wr_odd  = len_q[0];
          wr_addr = WAW'(len_q >> 1);
          len_d   = len_q + LW'(1);
        end
      end
      CHECK: begin
        wd_d = '0;
        if (32'(len_q) < MIN_L) begin
          drop_inc = 2'd1;
          state_d  = IDLE;
        end else begin
          state_d = HDR;
        end
      end
      HDR: begin
        if (hs) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        if (hs) begin
          if (last_word) begin
            pkt_inc = 1'b1;
            wd_d    = '0;
            state_d = IDLE;
          end else begin
            wd_d = wd_q + WCW'(1);
          end
        end
      end
      DROP: begin
        if (!enable_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new run arriving while a packet is still being framed is discarded.
    if (rise && (state_q == CHECK || state_q == HDR || state_q == PAYLOAD))
      drop_inc = drop_inc + 2'd1;

    rd_addr    = WAW'(wd_d);
    drop_sum   = {1'b0, drop_cnt_q} + {15'd0, drop_inc};
    pkt_sum    = {1'b0, pkt_cnt_q} + {16'd0, pkt_inc};
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    pkt_cnt_d  = pkt_sum[16]  ? 16'hFFFF : pkt_sum[15:0];
  end

  always_comb begin
    out_valid = 1'b0;
    m.tdata   = '0;
    m.tkeep   = 2'b00;
    m.tlast   = 1'b0;
    case (state_q)
      HDR: begin
        out_valid = 1'b1;
        m.tdata   = 16'(len_q);
        m.tkeep   = 2'b11;
      end
      PAYLOAD: begin
        out_valid = 1'b1;
        m.tlast   = last_word;
        if (last_word && len_q[0]) begin
          m.tdata = {rd_even_q, 8'h00};
          m.tkeep = 2'b10;
        end else begin
          m.tdata = {rd_even_q, rd_odd_q};
          m.tkeep = 2'b11;
        end
      end
      default: ;
    endcase
    m.tvalid = out_valid;
    busy     = (state_q != IDLE);
    pkt_cnt  = pkt_cnt_q;
    drop_cnt = drop_cnt_q;
  end

endmodule

// File: tb/tb_aurora_tx_framer.sv
// Randomised bench for aurora_tx_framer: expected frames come from a packet-level
// model (length rules plus byte pairing) and are matched against every handshake.
module tb_aurora_tx_framer;
  localparam int MAX_LEN = 1536;
  localparam int MIN_LEN = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_in;
  logic [7:0]  data_in;
  logic        busy;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;

  aurora_tx_framer_if axis();

  aurora_tx_framer #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
    .clk(clk), .rst(rst), .enable_in(enable_in), .data_in(data_in),
    .m(axis), .busy(busy), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [18:0] exp_q[$];
  int          exp_pkt = 0;
  int          exp_drop = 0;
  int          rdy_mode = 0;
  logic        prev_stall = 1'b0;
  logic [18:0] prev_word = '0;
  logic [18:0] mon_word;
  logic [7:0]  run_b[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Packet-level reference: length rules decide framing, then bytes pair up.
  function automatic void modelRun(input logic [7:0] b[$]);
    int n;
    int w;
    logic [7:0] lo;
    logic [1:0] kp;
    n = b.size();
    if (n < MIN_LEN || n > MAX_LEN) begin
      exp_drop++;
      return;
    end
    w = (n + 1) / 2;
    exp_q.push_back({1'b0, 2'b11, 16'(n)});
    for (int k = 0; k < w; k++) begin
      lo = (2*k + 1 < n) ? b[2*k + 1] : 8'h00;
      kp = (2*k + 1 < n) ? 2'b11 : 2'b10;
      exp_q.push_back({(k == w - 1), kp, b[2*k], lo});
    end
    exp_pkt++;
  endfunction

  task automatic applyStimulus(input logic [7:0] b[$]);
    foreach (b[i]) begin
      @(posedge clk); #1;
      enable_in = 1'b1;
      data_in   = b[i];
    end
    @(posedge clk); #1;
    enable_in = 1'b0;
  endtask

  task automatic makeRun(input int n, input int base);
    run_b.delete();
    for (int i = 0; i < n; i++)
      run_b.push_back((base < 0) ? 8'($urandom) : 8'(base + i));
  endtask

  task automatic waitIdle();
    int t;
    t = 0;
    repeat (3) @(negedge clk);
    while ((busy || exp_q.size() != 0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    checkOutput("frame_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_pkt_cnt"}, {16'd0, pkt_cnt}, 32'(exp_pkt));
    checkOutput({tag, "_drop_cnt"}, {16'd0, drop_cnt}, 32'(exp_drop));
  endtask

  initial begin
    axis.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: axis.tready = 1'b1;
        1: axis.tready = ~axis.tready;
        2: axis.tready = 1'($urandom_range(0, 1));
        default: axis.tready = 1'b0;
      endcase
    end
  end

  // Every handshake is matched against the model; stalled beats must hold.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      mon_word = {axis.tlast, axis.tkeep, axis.tdata};
      if (prev_stall)
        checkOutput("hold_stable", {12'd0, axis.tvalid, mon_word}, {12'd0, 1'b1, prev_word});
      if (axis.tvalid && axis.tready) begin
        if (exp_q.size() == 0)
          checkOutput("unexpected_word", {13'd0, mon_word}, 32'hFFFFFFFF);
        else
          checkOutput("word", {13'd0, mon_word}, {13'd0, exp_q.pop_front()});
      end
      prev_stall = axis.tvalid && !axis.tready;
      prev_word  = mon_word;
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int burst;
    int lens[4];
    rst       = 1'b1;
    enable_in = 1'b0;
    data_in   = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rst_tvalid", {31'd0, axis.tvalid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_out", {13'd0, axis.tlast, axis.tkeep, axis.tdata}, 32'd0);
    checkCounters("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: nominal even packet, also timing of header and back-to-back words
    rdy_mode = 0;
    makeRun(10, 1);
    modelRun(run_b);
    applyStimulus(run_b);
    lat = 0;
    while (!axis.tvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("hdr_latency_ok", {31'd0, (lat >= 1 && lat <= 4)}, 32'd1);
    burst = 0;
    while (axis.tvalid && burst < 20) begin
      @(negedge clk);
      burst++;
    end
    checkOutput("burst_len", 32'(burst), 32'd6);
    waitIdle();
    checkCounters("t1");

    // T2: odd length under alternating back-pressure
    rdy_mode = 1;
    makeRun(9, 8'h11);
    modelRun(run_b);
    applyStimulus(run_b);
    waitIdle();
    checkCounters("t2");

    // T3: glitch then a minimum-length packet
    rdy_mode = 0;
    makeRun(5, -1);
    modelRun(run_b);
    applyStimulus(run_b);
    waitIdle();
    makeRun(8, -1);
    modelRun(run_b);
    applyStimulus(run_b);
    waitIdle();
    checkCounters("t3");

    // T4: overflow then a 20-byte packet
    makeRun(MAX_LEN + 3, -1);
    modelRun(run_b);
    applyStimulus(run_b);
    waitIdle();
    makeRun(20, -1);
    modelRun(run_b);
    applyStimulus(run_b);
    waitIdle();
    checkCounters("t4");

    // Length boundaries around both limits
    lens = '{MIN_LEN - 1, MAX_LEN, MAX_LEN + 1, 1};
    foreach (lens[i]) begin
      rdy_mode = 2;
      makeRun(lens[i], -1);
      modelRun(run_b);
      applyStimulus(run_b);
      waitIdle();
    end
    checkCounters("bound");

    // Random lengths, data and back-pressure
    for (int r = 0; r < 14; r++) begin
      rdy_mode = int'($urandom_range(0, 2));
      makeRun(int'($urandom_range(1, 40)), -1);
      modelRun(run_b);
      applyStimulus(run_b);
      waitIdle();
    end
    checkCounters("rand");

    // T5: overlapping run starts while the frame is stalled
    rdy_mode = 3;
    makeRun(10, -1);
    modelRun(run_b);
    applyStimulus(run_b);
    lat = 0;
    while (!axis.tvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("t5_hdr_seen", {31'd0, axis.tvalid}, 32'd1);
    @(posedge clk); #1;
    enable_in = 1'b1;
    data_in   = 8'h5A;
    exp_drop++;
    repeat (5) @(posedge clk);
    rdy_mode = 0;
    waitIdle();
    repeat (5) @(negedge clk);
    checkOutput("t5_still_idle", {31'd0, busy}, 32'd0);
    checkCounters("t5");
    @(posedge clk); #1;
    enable_in = 1'b0;

    // Rise in the same cycle as the final handshake
    makeRun(8, -1);
    modelRun(run_b);
    applyStimulus(run_b);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(axis.tvalid && axis.tlast && axis.tready) && lat < 40);
    checkOutput("t5b_last_seen", {31'd0, axis.tlast}, 32'd1);
    enable_in = 1'b1;
    exp_drop++;
    waitIdle();
    repeat (3) @(negedge clk);
    checkOutput("t5b_still_idle", {31'd0, busy}, 32'd0);
    checkCounters("t5b");
    @(posedge clk); #1;
    enable_in = 1'b0;

    // T6: reset during payload with enable_in held high across release
    rdy_mode = 1;
    makeRun(16, -1);
    modelRun(run_b);
    applyStimulus(run_b);
    lat = 0;
    while (!axis.tvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    rst       = 1'b1;
    enable_in = 1'b1;
    data_in   = 8'hAA;
    exp_q.delete();
    exp_pkt  = 0;
    exp_drop = 0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t6_tvalid", {31'd0, axis.tvalid}, 32'd0);
    checkOutput("t6_busy", {31'd0, busy}, 32'd0);
    checkCounters("t6_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("t6_no_capture", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    enable_in = 1'b0;
    makeRun(8, -1);
    modelRun(run_b);
    applyStimulus(run_b);
    waitIdle();
    checkCounters("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
